// File: rtl/result_streamer.sv
// result_streamer: readout stage of the multicore top level.
// Reads rows of the shared wide data memory (CORE_COUNT lanes of MEM_WIDTH bits)
// and serializes each row, lane 0 first, onto a valid/ready output stream.
// The internal address register drives mem_addr at all times; the top level
// muxes it onto the memory port while this block is busy.
// Optional feature: define RESULT_STREAMER_CHECKSUM_EN to append one checksum word
// (sum of all streamed data words modulo 2^MEM_WIDTH) after the final data word.
module result_streamer #(
  parameter int MEM_WIDTH  = 12,
  parameter int CORE_COUNT = 3,
  parameter int MEM_ADDR   = 11,
  localparam int LANE_W    = (CORE_COUNT > 1) ? $clog2(CORE_COUNT) : 1
) (
  input  logic                            clock,
  input  logic                            reset,
  input  logic                            start,
  input  logic [MEM_ADDR-1:0]             base_addr,
  input  logic [MEM_ADDR:0]               row_count,
  output logic [MEM_ADDR-1:0]             mem_addr,
  input  logic [MEM_WIDTH*CORE_COUNT-1:0] mem_rd_data,
  output logic [MEM_WIDTH-1:0]            out_data,
  output logic [LANE_W-1:0]               out_lane,
  output logic                            out_valid,
  input  logic                            out_ready,
  output logic                            out_last,
  output logic                            busy,
  output logic                            done
);

  localparam logic [LANE_W-1:0] LastLane = LANE_W'(CORE_COUNT - 1);

  typedef enum logic [2:0] {
    StIdle,
    StRead,
    StLatch,
    StSend,
    StDone
`ifdef RESULT_STREAMER_CHECKSUM_EN
    , StChecksum
`endif
  } stateType;

  stateType                      stateReg;
  stateType                      stateNext;
  logic [MEM_ADDR-1:0]           addrReg;
  logic [MEM_ADDR:0]             remaining;
  logic [LANE_W-1:0]             laneReg;
  logic [MEM_WIDTH*CORE_COUNT-1:0] rowBuffer;
  logic [MEM_WIDTH-1:0]          laneWord;
  logic                          lastLane;
  logic                          finalRow;
  logic                          sendFire;
`ifdef RESULT_STREAMER_CHECKSUM_EN
  logic [MEM_WIDTH-1:0]          checksum;
`endif

  assign lastLane = (laneReg == LastLane);
  assign finalRow = (remaining == (MEM_ADDR + 1)'(1));
  assign sendFire = (stateReg == StSend) && out_ready;
  assign mem_addr = addrReg;
  assign busy     = (stateReg != StIdle);
  assign done     = (stateReg == StDone);

  // State register.
  always_ff @(posedge clock) begin
    // NOTE: sequential state uses non-blocking assignments so every flop samples
    // pre-edge values regardless of statement order.
    if (reset) begin
      stateReg <= StIdle;
    end else begin
      stateReg <= stateNext;
    end
  end

  // Next-state decode, lane select and stream outputs.
  always_comb begin
    // NOTE: every output of this block gets a default first, so no path leaves a
    // signal unassigned and no latch is inferred.
    stateNext = stateReg;
    laneWord  = '0;
    out_valid = 1'b0;
    out_data  = '0;
    out_lane  = '0;
    out_last  = 1'b0;

    for (int i = 0; i < CORE_COUNT; i++) begin
      if (laneReg == LANE_W'(i)) begin
        laneWord = rowBuffer[i*MEM_WIDTH +: MEM_WIDTH];
      end
    end

    case (stateReg)
      StIdle: begin
        if (start) begin
          if (row_count == '0) begin
`ifdef RESULT_STREAMER_CHECKSUM_EN
            stateNext = StChecksum;
`else
            stateNext = StDone;
`endif
          end else begin
            stateNext = StRead;
          end
        end
      end
      StRead:  stateNext = StLatch;
      StLatch: stateNext = StSend;
      StSend: begin
        out_valid = 1'b1;
        out_data  = laneWord;
        out_lane  = laneReg;
`ifdef RESULT_STREAMER_CHECKSUM_EN
        out_last  = 1'b0;
`else
        out_last  = lastLane && finalRow;
`endif
        if (out_ready && lastLane) begin
          if (finalRow) begin
`ifdef RESULT_STREAMER_CHECKSUM_EN
            stateNext = StChecksum;
`else
            stateNext = StDone;
`endif
          end else begin
            stateNext = StRead;
          end
        end
      end
`ifdef RESULT_STREAMER_CHECKSUM_EN
      StChecksum: begin
        out_valid = 1'b1;
        out_data  = checksum;
        out_lane  = '0;
        out_last  = 1'b1;
        if (out_ready) begin
          stateNext = StDone;
        end
      end
`endif
      StDone:  stateNext = StIdle;
      default: stateNext = StIdle;
    endcase
  end

  // Address, row counter, lane counter, row buffer and checksum accumulator.
  always_ff @(posedge clock) begin
    if (reset) begin
      addrReg   <= '0;
      remaining <= '0;
      laneReg   <= '0;
      // NOTE: the row buffer is ordinary flops rather than a RAM, so it is cleared
      // here along with the rest of the datapath.
      rowBuffer <= '0;
`ifdef RESULT_STREAMER_CHECKSUM_EN
      checksum  <= '0;
`endif
    end else begin
      case (stateReg)
        StIdle: begin
          if (start) begin
            addrReg   <= base_addr;
            remaining <= row_count;
`ifdef RESULT_STREAMER_CHECKSUM_EN
            checksum  <= '0;
`endif
          end
        end
        StLatch: begin
          rowBuffer <= mem_rd_data;
          laneReg   <= '0;
        end
        StSend: begin
          if (sendFire) begin
`ifdef RESULT_STREAMER_CHECKSUM_EN
            checksum <= checksum + laneWord;
`endif
            if (lastLane) begin
              laneReg   <= '0;
              remaining <= remaining - (MEM_ADDR + 1)'(1);
              addrReg   <= addrReg + MEM_ADDR'(1);
            end else begin
              laneReg <= laneReg + LANE_W'(1);
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_result_streamer.sv
// tb_result_streamer: directed bench for result_streamer with a scoreboard.
// Expected words are computed from the bench's own memory image when a transfer
// is started; a consumer process pops and compares them on each handshake.
module tb_result_streamer;

  localparam int MEM_WIDTH  = 12;
  localparam int CORE_COUNT = 3;
  localparam int MEM_ADDR   = 11;
  localparam int LANE_W     = 2;
  localparam int ROW_W      = MEM_WIDTH * CORE_COUNT;
  localparam int DEPTH      = 1 << MEM_ADDR;
`ifdef RESULT_STREAMER_CHECKSUM_EN
  localparam bit CHECKSUM_EN = 1'b1;
  localparam int EXTRA_WORD  = 1;
`else
  localparam bit CHECKSUM_EN = 1'b0;
  localparam int EXTRA_WORD  = 0;
`endif

  typedef struct packed {
    logic [MEM_WIDTH-1:0] data;
    logic [LANE_W-1:0]    lane;
    logic                 last;
  } wordType;

  logic                 clock = 1'b0;
  logic                 reset;
  logic                 start;
  logic [MEM_ADDR-1:0]  base_addr;
  logic [MEM_ADDR:0]    row_count;
  logic [MEM_ADDR-1:0]  mem_addr;
  logic [ROW_W-1:0]     mem_rd_data;
  logic [MEM_WIDTH-1:0] out_data;
  logic [LANE_W-1:0]    out_lane;
  logic                 out_valid;
  logic                 out_ready = 1'b1;
  logic                 out_last;
  logic                 busy;
  logic                 done;

  logic [ROW_W-1:0] mem [0:DEPTH-1];
  wordType          sbQueue[$];
  int               testCount = 0;
  int               failCount = 0;
  bit               stallMode = 1'b0;
  bit               prevStall = 1'b0;
  int               stallCnt  = 0;
  int               wordNum   = 0;
  wordType          gotWord;
  wordType          heldWord;
  wordType          expWord;

  result_streamer #(
    .MEM_WIDTH (MEM_WIDTH),
    .CORE_COUNT(CORE_COUNT),
    .MEM_ADDR  (MEM_ADDR)
  ) dut (
    .clock      (clock),
    .reset      (reset),
    .start      (start),
    .base_addr  (base_addr),
    .row_count  (row_count),
    .mem_addr   (mem_addr),
    .mem_rd_data(mem_rd_data),
    .out_data   (out_data),
    .out_lane   (out_lane),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_last   (out_last),
    .busy       (busy),
    .done       (done)
  );

  always #5 clock = ~clock;

  // Synchronous-read memory model: data valid one cycle after the address.
  always @(posedge clock) mem_rd_data <= mem[mem_addr];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    testCount++;
    assert (obs === exp) else begin
      failCount++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [ROW_W-1:0] mkRow(input int a);
    logic [ROW_W-1:0] r;
    for (int l = 0; l < CORE_COUNT; l++) r[l*MEM_WIDTH +: MEM_WIDTH] = MEM_WIDTH'(a * CORE_COUNT + l);
    return r;
  endfunction

  // Push the words a transfer of `rows` rows from `base` must produce.
  task automatic expectTransfer(input int base, input int rows);
    logic [MEM_WIDTH-1:0] sum;
    logic [ROW_W-1:0]     row;
    wordType              w;
    sum = '0;
    for (int r = 0; r < rows; r++) begin
      row = mem[(base + r) % DEPTH];
      for (int l = 0; l < CORE_COUNT; l++) begin
        w.data = row[l*MEM_WIDTH +: MEM_WIDTH];
        w.lane = LANE_W'(l);
        w.last = !CHECKSUM_EN && (r == rows - 1) && (l == CORE_COUNT - 1);
        sum    = sum + w.data;
        sbQueue.push_back(w);
      end
    end
    if (CHECKSUM_EN) begin
      w.data = sum;
      w.lane = '0;
      w.last = 1'b1;
      sbQueue.push_back(w);
    end
  endtask

  // Wait (bounded) for done, then step one cycle and confirm the block is idle.
  task automatic waitDone(input string tag, input int budget);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < budget && !seen; i++) begin
      @(negedge clock);
      seen = done;
    end
    check({tag, " done seen"}, seen, 1);
    @(negedge clock);
    check({tag, " idle after done"}, busy, 0);
    check({tag, " sb empty"}, sbQueue.size(), 0);
  endtask

  // Consumer: drives out_ready, checks stall stability, pops the scoreboard.
  always @(negedge clock) begin
    gotWord = '{data: out_data, lane: out_lane, last: out_last};
    if (prevStall) begin
      check("stall valid held", out_valid, 1);
      check("stall word held", gotWord, heldWord);
    end
    if (stallMode && out_valid && wordNum[0] && stallCnt < 2) begin
      out_ready = 1'b0;
      stallCnt++;
    end else begin
      out_ready = 1'b1;
    end
    if (out_valid && out_ready) begin
      check("word expected", sbQueue.size() != 0, 1);
      if (sbQueue.size() != 0) begin
        expWord = sbQueue.pop_front();
        check($sformatf("word %0d data", wordNum), gotWord.data, expWord.data);
        check($sformatf("word %0d lane", wordNum), gotWord.lane, expWord.lane);
        check($sformatf("word %0d last", wordNum), gotWord.last, expWord.last);
      end
      wordNum++;
      stallCnt = 0;
    end
    prevStall = out_valid && !out_ready;
    heldWord  = gotWord;
  end

  initial begin
    for (int a = 0; a < DEPTH; a++) mem[a] = mkRow(a);
    mem[5]  = {12'h003, 12'h002, 12'h001};
    mem[10] = {12'd3, 12'd2, 12'd1};
    mem[11] = {12'd6, 12'd5, 12'd4};

    reset = 1'b1; start = 1'b0; base_addr = '0; row_count = '0;
    repeat (3) @(negedge clock);
    check("rst out_valid", out_valid, 0);
    check("rst out_data", out_data, 0);
    check("rst out_lane", out_lane, 0);
    check("rst out_last", out_last, 0);
    check("rst busy", busy, 0);
    check("rst done", done, 0);
    check("rst mem_addr", mem_addr, 0);
    reset = 1'b0;
    @(negedge clock);

    // Single row at 5: words in cycles 3..5, done in cycle 6 (one later with checksum).
    base_addr = 11'd5; row_count = 12'd1; start = 1'b1;
    expectTransfer(5, 1);
    for (int c = 1; c <= 7 + EXTRA_WORD; c++) begin
      @(negedge clock);
      if (c == 1) start = 1'b0;
      check($sformatf("t1 valid c%0d", c), out_valid, (c >= 3) && (c <= 5 + EXTRA_WORD));
      check($sformatf("t1 done c%0d", c), done, c == 6 + EXTRA_WORD);
      check($sformatf("t1 busy c%0d", c), busy, c <= 6 + EXTRA_WORD);
    end
    check("t1 sb empty", sbQueue.size(), 0);

    // Four rows with consumer stalls; a start pulse mid-transfer must be ignored.
    stallMode = 1'b1;
    base_addr = 11'd0; row_count = 12'd4; start = 1'b1;
    expectTransfer(0, 4);
    @(negedge clock);
    start = 1'b0;
    repeat (4) @(negedge clock);
    base_addr = 11'd100; row_count = 12'd1; start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    check("t2 busy", busy, 1);
    waitDone("t2", 300);
    stallMode = 1'b0;

    // Zero rows.
    base_addr = 11'd7; row_count = 12'd0; start = 1'b1;
    expectTransfer(7, 0);
    @(negedge clock);
    start = 1'b0;
`ifdef RESULT_STREAMER_CHECKSUM_EN
    check("t3 c1 valid", out_valid, 1);
    check("t3 c1 busy", busy, 1);
    check("t3 c1 done", done, 0);
    @(negedge clock);
    check("t3 c2 done", done, 1);
    check("t3 c2 valid", out_valid, 0);
    @(negedge clock);
    check("t3 c3 busy", busy, 0);
`else
    check("t3 c1 done", done, 1);
    check("t3 c1 busy", busy, 1);
    check("t3 c1 valid", out_valid, 0);
    @(negedge clock);
    check("t3 c2 done", done, 0);
    check("t3 c2 busy", busy, 0);
    check("t3 c2 valid", out_valid, 0);
`endif
    check("t3 sb empty", sbQueue.size(), 0);

    // Address wrap from 2047 to 0.
    base_addr = 11'd2047; row_count = 12'd2; start = 1'b1;
    expectTransfer(2047, 2);
    @(negedge clock);
    start = 1'b0;
    check("t4 addr row0", mem_addr, 2047);
    repeat (5) @(negedge clock);
    check("t4 addr row1", mem_addr, 0);
    waitDone("t4", 50);

    // Reset during SEND of the second row, then a fresh transfer.
    base_addr = 11'd0; row_count = 12'd4; start = 1'b1;
    expectTransfer(0, 4);
    @(negedge clock);
    start = 1'b0;
    repeat (8) @(negedge clock);
    check("t5 in send", out_valid, 1);
    check("t5 lane", out_lane, 1);
    reset = 1'b1;
    @(negedge clock);
    check("t5 rst valid", out_valid, 0);
    check("t5 rst data", out_data, 0);
    check("t5 rst lane", out_lane, 0);
    check("t5 rst last", out_last, 0);
    check("t5 rst busy", busy, 0);
    check("t5 rst done", done, 0);
    check("t5 rst addr", mem_addr, 0);
    sbQueue.delete();
    reset = 1'b0;
    @(negedge clock);
    base_addr = 11'd20; row_count = 12'd1; start = 1'b1;
    expectTransfer(20, 1);
    @(negedge clock);
    start = 1'b0;
    check("t5 restart addr", mem_addr, 20);
    waitDone("t5", 50);

    // Rows {1,2,3} and {4,5,6}; with the checksum build a seventh word of 21.
    base_addr = 11'd10; row_count = 12'd2; start = 1'b1;
    expectTransfer(10, 2);
    @(negedge clock);
    start = 1'b0;
    waitDone("t6", 50);

    $display("[TB] %0d tests run, %0d failed", testCount, failCount);
    $finish;
  end

endmodule

// File: doc/result_streamer.md
Name: result_streamer

Overview:
- Downstream readout stage of the multicore top level.
- After the processors finish, it reads a region of the shared wide data memory one row (CORE_COUNT lanes × MEM_WIDTH bits) at a time.
- Each row is serialized lane by lane onto a valid/ready output stream for host or testbench collection.
- It owns the data-memory address while busy; the top level muxes its address in during its finish state.

Parameters:
- MEM_WIDTH, 12, bits per core lane.
- CORE_COUNT, 3, lanes per memory row.
- MEM_ADDR, 11, data-memory address width.

Ports:
- clock  input  1  system clock.
- reset  input  1  synchronous, active-high reset.
- start  input  1  single-cycle request to begin readout; ignored unless in IDLE.
- base_addr  input  MEM_ADDR  first row address; sampled on an accepted start.
- row_count  input  MEM_ADDR+1  number of rows to stream; sampled on an accepted start.
- mem_addr  output  MEM_ADDR  data-memory read address.
- mem_rd_data  input  MEM_WIDTH*CORE_COUNT  synchronous-read memory data, valid one cycle after mem_addr.
- out_data  output  MEM_WIDTH  current lane word.
- out_lane  output  $clog2(CORE_COUNT) (min 1)  lane index of out_data.
- out_valid  output  1  out_data is valid.
- out_ready  input  1  consumer accepts the word when high together with out_valid.
- out_last  output  1  marks the final word of the transfer.
- busy  output  1  high in every state except IDLE.
- done  output  1  one-cycle pulse at the end of a transfer.

Behaviour:
- Reset: all outputs 0; state IDLE; internal address, row counter, lane counter and row buffer cleared.
- mem_addr always reflects the internal address register.
- IDLE:
  - start=1 latches base_addr into addr and row_count into remaining.
  - If row_count==0, go to DONE. Otherwise go to READ.
- READ:
  - mem_addr=addr for one cycle, then go to LATCH.
- LATCH:
  - Capture mem_rd_data into the row buffer; lane=0; go to SEND.
- SEND:
  - out_valid=1; out_data=buffer[lane*MEM_WIDTH +: MEM_WIDTH]. Lane 0 is the LSBs.
  - out_data, out_lane and out_last are held stable while out_valid=1 and out_ready=0.
  - On handshake with lane<CORE_COUNT-1: lane+1.
  - On handshake with lane==CORE_COUNT-1: remaining-1 and addr+1. Go to DONE if remaining was 1, else go to READ.
- DONE:
  - done=1 for exactly one cycle; busy=0 from the next cycle; go to IDLE.
- Latency: start accepted in cycle 0 gives READ in cycle 1, LATCH in cycle 2, and first out_valid in cycle 3. Each subsequent row adds 2 bubble cycles before its first lane.
- out_last=1 only on lane CORE_COUNT-1 of the final row.
- Address wrap: addr increments modulo 2^MEM_ADDR, so 2047+1=0 for MEM_ADDR=11.
- start while busy is ignored; it has no effect on the transfer in progress.
- Reset mid-transfer returns to IDLE immediately; the partially sent row is discarded and done is not pulsed.
- out_ready is don't-care when out_valid=0.
- The row buffer updates only in LATCH.

Optional Feature:
- Macro: RESULT_STREAMER_CHECKSUM_EN.
- Enabled:
  - An accumulator sums every handshaked data word modulo 2^MEM_WIDTH. It is cleared on an accepted start.
  - After the final data word, a CHECKSUM state emits one extra word: out_data=sum, out_lane=0, out_last=1.
  - The last data word then has out_last=0.
  - done pulses after the checksum handshake.
  - row_count==0 emits a single checksum word of 0.
- Disabled: no accumulator and no CHECKSUM state; behaviour is exactly as above.

Test Plan:
- Row at 5 = {12'h003,12'h002,12'h001}, base_addr=5, row_count=1, out_ready=1 -> out_data 1,2,3 in cycles 3,4,5; out_last on the 3rd word; done in cycle 6.
- Rows 0..3 each hold lane value (row*3+lane), row_count=4, out_ready held low 2 cycles on every other word -> 12 words in order 0..11 with no duplicates or drops; data stable during stalls.
- row_count=0 -> no out_valid; done pulses one cycle after start; busy high for exactly 1 cycle.
- base_addr=2047, row_count=2 -> mem_addr sequence 2047 then 0; 6 words streamed.
- Reset asserted while in SEND of row 2 of 4 -> next cycle all outputs 0, state IDLE; a new start streams correctly from its base_addr.
- Checksum build, rows {1,2,3} and {4,5,6} -> 7th word = 21 with out_last; 6th word has out_last=0.
